cpu_host_seq: RTL and testbench

- Host-side run sequencer sitting directly upstream of the processor top level.
- Holds the processor in reset and owns the data-memory port while it streams LOAD_LEN operand bytes into data memory.
- Then releases the processor, pulses its req, and waits for done or a watchdog timeout.
- Finally streams RES_LEN result bytes back out to the host with a valid/ready handshake.

---
 rtl/cpu_host_seq_pkg.sv | 31 +++
 rtl/cpu_host_seq_if.sv | 28 ++
 rtl/cpu_host_seq_wdog.sv | 29 ++
 rtl/cpu_host_seq.sv | 153 +++++++++++++++
 tb/tb_cpu_host_seq.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_host_seq_pkg.sv
// Shared definitions for the host run sequencer: state encoding and the
// default data-memory map used by both the RTL and its bench.
package cpu_host_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        FIN
    } seq_state_t;

    localparam int unsigned DEF_AW        = 8;
    localparam int unsigned DEF_DW        = 8;
    localparam int unsigned DEF_LOAD_BASE = 0;
    localparam int unsigned DEF_LOAD_LEN  = 32;
    localparam int unsigned DEF_RES_BASE  = 64;
    localparam int unsigned DEF_RES_LEN   = 32;
    localparam int unsigned DEF_TMO       = 4096;

    // Width able to hold the largest of the three counts.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cpu_host_seq_if.sv
// Data-memory port shared between the host sequencer (master) and the
// memory/arbiter side (slave).
interface cpu_host_seq_if #(
    parameter int unsigned AW = cpu_host_seq_pkg::DEF_AW,
    parameter int unsigned DW = cpu_host_seq_pkg::DEF_DW
);
    logic          mem_sel;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dat_in;
    logic [DW-1:0] mem_dat_out;

    modport master (
        output mem_sel,
        output mem_wr_en,
        output mem_addr,
        output mem_dat_in,
        input  mem_dat_out
    );

    modport slave (
        input  mem_sel,
        input  mem_wr_en,
        input  mem_addr,
        input  mem_dat_in,
        output mem_dat_out
    );
endinterface

// File: rtl/cpu_host_seq_wdog.sv
// Loadable cycle counter with clear/enable; expire flags the final count
// (limit_m1) so the caller can act on the same cycle.
module seq_wdog #(
    parameter int unsigned CW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    input  logic [CW-1:0] limit_m1,
    output logic [CW-1:0] count,
    output logic          expire
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (ld) begin
            count <= ld_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == limit_m1);
endmodule

// File: rtl/cpu_host_seq.sv
// Host run sequencer: loads operands into data memory, runs the processor
// under a watchdog, then streams results back to the host.
module cpu_host_seq
    import cpu_host_seq_pkg::*;
#(
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned LOAD_BASE = DEF_LOAD_BASE,
    parameter int unsigned LOAD_LEN  = DEF_LOAD_LEN,
    parameter int unsigned RES_BASE  = DEF_RES_BASE,
    parameter int unsigned RES_LEN   = DEF_RES_LEN,
    parameter int unsigned TMO       = DEF_TMO
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           ld_valid,
    input  logic [DW-1:0]  ld_data,
    output logic           ld_ready,
    output logic           res_valid,
    output logic [DW-1:0]  res_data,
    input  logic           res_ready,
    output logic           busy,
    output logic           host_done,
    output logic           timeout,
    output logic           cpu_reset,
    output logic           cpu_req,
    input  logic           cpu_done,
    cpu_host_seq_if.master mem
);
    localparam int unsigned CW = cnt_width(LOAD_LEN, RES_LEN, TMO);

    seq_state_t    state;
    logic          mem_sel_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wdog;
    logic [CW-1:0] cnt_limit;
    logic          cnt_last;
    logic          wdog_last;
    logic          start_acc;
    logic          ld_beat;
    logic          res_beat;
    logic          cnt_clr;

    assign start_acc = (state == IDLE) && start;
    assign ld_beat   = ld_ready && ld_valid;
    assign res_beat  = res_valid && res_ready;
    assign cnt_clr   = start_acc || (ld_beat && cnt_last);
    assign cnt_limit = (state == DRAIN) ? CW'(RES_LEN - 1) : CW'(LOAD_LEN - 1);

    seq_wdog #(.CW(CW)) u_beat (
        .clk      (clk),
        .rst      (reset),
        .clr      (cnt_clr),
        .en       (ld_beat || res_beat),
        .ld       (1'b0),
        .ld_val   ('0),
        .limit_m1 (cnt_limit),
        .count    (cnt),
        .expire   (cnt_last)
    );

    seq_wdog #(.CW(CW)) u_wdog (
        .clk      (clk),
        .rst      (reset),
        .clr      (start_acc),
        .en       (state == RUN),
        .ld       (1'b0),
        .ld_val   ('0),
        .limit_m1 (CW'(TMO - 1)),
        .count    (wdog),
        .expire   (wdog_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ld_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            host_done <= 1'b0;
            timeout   <= 1'b0;
            cpu_reset <= 1'b1;
            cpu_req   <= 1'b0;
            mem_sel_q <= 1'b1;
        end else begin
            host_done <= 1'b0;
            cpu_req   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                        timeout  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ld_beat && cnt_last) begin
                        state     <= RUN;
                        ld_ready  <= 1'b0;
                        cpu_reset <= 1'b0;
                        cpu_req   <= 1'b1;
                        mem_sel_q <= 1'b0;
                    end
                end
                RUN: begin
                    // wdog is still 0 on the first RUN cycle, masking a stale done
                    if (cpu_done && (wdog != '0)) begin
                        state     <= DRAIN;
                        res_valid <= 1'b1;
                        cpu_reset <= 1'b1;
                        mem_sel_q <= 1'b1;
                    end else if (wdog_last) begin
                        state     <= FIN;
                        timeout   <= 1'b1;
                        host_done <= 1'b1;
                        cpu_reset <= 1'b1;
                        mem_sel_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (res_beat && cnt_last) begin
                        state     <= FIN;
                        res_valid <= 1'b0;
                        host_done <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem.mem_wr_en  = ld_beat;
        mem.mem_dat_in = ld_beat ? ld_data : '0;
        mem.mem_addr   = '0;
        res_data       = '0;
        if (state == LOAD) begin
            mem.mem_addr = AW'(LOAD_BASE) + AW'(cnt);
        end
        if (state == DRAIN) begin
            mem.mem_addr = AW'(RES_BASE) + AW'(cnt);
            res_data     = mem.mem_dat_out;
        end
    end

    assign mem.mem_sel = mem_sel_q;
endmodule

// File: tb/tb_cpu_host_seq.sv
// Directed-plus-random bench for cpu_host_seq: a default instance and a small
// instance with wrapping addresses and a short watchdog.
module tb_cpu_host_seq;
    import cpu_host_seq_pkg::*;

    localparam int unsigned T_TMO = 16;
    localparam int unsigned T_LB  = 250;
    localparam int unsigned T_LL  = 8;
    localparam int unsigned T_RB  = 254;
    localparam int unsigned T_RL  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, act;
    logic       a_start, a_cpu_done, ld_valid, res_ready;
    logic [7:0] ld_data;
    logic       pl_en, pl_sel;
    logic [7:0] pl_addr, pl_data;

    logic       start0, cpu_done0, ld_ready0, res_valid0, busy0, host_done0, timeout0, cpu_reset0, cpu_req0;
    logic       start1, cpu_done1, ld_ready1, res_valid1, busy1, host_done1, timeout1, cpu_reset1, cpu_req1;
    logic [7:0] res_data0, res_data1;

    logic [7:0] memm [2][256];
    logic [7:0] refm [2][256];

    int unsigned checks = 0;
    int unsigned errors = 0;

    cpu_host_seq_if #(.AW(8), .DW(8)) mb0 ();
    cpu_host_seq_if #(.AW(8), .DW(8)) mb1 ();

    assign start0    = a_start && !act;
    assign start1    = a_start && act;
    assign cpu_done0 = a_cpu_done && !act;
    assign cpu_done1 = a_cpu_done && act;

    cpu_host_seq u_dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready0),
        .res_valid(res_valid0), .res_data(res_data0), .res_ready(res_ready),
        .busy(busy0), .host_done(host_done0), .timeout(timeout0),
        .cpu_reset(cpu_reset0), .cpu_req(cpu_req0), .cpu_done(cpu_done0),
        .mem(mb0)
    );

    cpu_host_seq #(
        .TMO(T_TMO), .LOAD_BASE(T_LB), .LOAD_LEN(T_LL), .RES_BASE(T_RB), .RES_LEN(T_RL)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready1),
        .res_valid(res_valid1), .res_data(res_data1), .res_ready(res_ready),
        .busy(busy1), .host_done(host_done1), .timeout(timeout1),
        .cpu_reset(cpu_reset1), .cpu_req(cpu_req1), .cpu_done(cpu_done1),
        .mem(mb1)
    );

    // Data memories: sequencer writes when it owns the port, plus a bench preload port.
    always @(posedge clk) begin
        if (pl_en) memm[pl_sel][pl_addr] <= pl_data;
        if (mb0.mem_sel && mb0.mem_wr_en) memm[0][mb0.mem_addr] <= mb0.mem_dat_in;
        if (mb1.mem_sel && mb1.mem_wr_en) memm[1][mb1.mem_addr] <= mb1.mem_dat_in;
    end
    assign mb0.mem_dat_out = memm[0][mb0.mem_addr];
    assign mb1.mem_dat_out = memm[1][mb1.mem_addr];

    logic       a_ld_ready, a_res_valid, a_busy, a_host_done, a_timeout, a_cpu_reset, a_cpu_req;
    logic       a_mem_sel, a_mem_wr_en;
    logic [7:0] a_res_data, a_mem_addr, a_mem_dat_in;
    always_comb begin
        a_ld_ready   = act ? ld_ready1   : ld_ready0;
        a_res_valid  = act ? res_valid1  : res_valid0;
        a_busy       = act ? busy1       : busy0;
        a_host_done  = act ? host_done1  : host_done0;
        a_timeout    = act ? timeout1    : timeout0;
        a_cpu_reset  = act ? cpu_reset1  : cpu_reset0;
        a_cpu_req    = act ? cpu_req1    : cpu_req0;
        a_res_data   = act ? res_data1   : res_data0;
        a_mem_sel    = act ? mb1.mem_sel    : mb0.mem_sel;
        a_mem_wr_en  = act ? mb1.mem_wr_en  : mb0.mem_wr_en;
        a_mem_addr   = act ? mb1.mem_addr   : mb0.mem_addr;
        a_mem_dat_in = act ? mb1.mem_dat_in : mb0.mem_dat_in;
    end

    function automatic int unsigned lbase(); return act ? T_LB : DEF_LOAD_BASE; endfunction
    function automatic int unsigned llen();  return act ? T_LL : DEF_LOAD_LEN;  endfunction
    function automatic int unsigned rbase(); return act ? T_RB : DEF_RES_BASE;  endfunction
    function automatic int unsigned rlen();  return act ? T_RL : DEF_RES_LEN;   endfunction
    function automatic int unsigned tmo();   return act ? T_TMO : DEF_TMO;      endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input bit pattern);
        for (int unsigned i = 0; i < rlen(); i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_sel  = act;
            pl_addr = 8'((rbase() + i) % 256);
            pl_data = pattern ? 8'(8'hA0 + i) : 8'($urandom);
            refm[act][pl_addr] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("start_ld_ready", a_ld_ready, 1);
        chk("start_busy", a_busy, 1);
        chk("start_timeout_clr", a_timeout, 0);
        chk("start_cpu_reset", a_cpu_reset, 1);
    endtask

    // mode 0: valid every cycle, data = index; 1: valid every other cycle; 2: random
    task automatic do_load(input int mode);
        int unsigned i, cyc, nbad;
        logic [7:0]  d;
        logic        v;
        i   = 0;
        cyc = 0;
        while (i < llen()) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            d = (mode == 0) ? 8'(i) : 8'($urandom);
            ld_valid = v;
            ld_data  = d;
            #1;
            chk("ld_wr_en", a_mem_wr_en, v);
            chk("ld_busy", a_busy, 1);
            if (v) begin
                chk("ld_addr", a_mem_addr, (lbase() + i) % 256);
                chk("ld_dat_in", a_mem_dat_in, d);
                refm[act][8'((lbase() + i) % 256)] = d;
                i++;
            end
            cyc++;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_data  = '0;
        chk("run_cpu_req", a_cpu_req, 1);
        chk("run_cpu_reset", a_cpu_reset, 0);
        chk("run_mem_sel", a_mem_sel, 0);
        chk("run_ld_ready", a_ld_ready, 0);
        nbad = 0;
        for (int unsigned k = 0; k < llen(); k++)
            if (memm[act][8'((lbase() + k) % 256)] !== refm[act][8'((lbase() + k) % 256)]) nbad++;
        chk("load_mem_contents", nbad, 0);
    endtask

    // d: cycle (0 = first RUN cycle) at which cpu_done rises and stays high; d < 0 never
    task automatic do_run(input int d);
        int  acc, last;
        bit  to;
        acc  = (d < 0) ? 32'h3fff_ffff : ((d < 1) ? 1 : d);
        to   = acc > int'(tmo()) - 1;
        last = to ? int'(tmo()) - 1 : acc;
        if (d == 0) a_cpu_done = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == d) a_cpu_done = 1'b1;
            if (k == 1) chk("req_one_cycle", a_cpu_req, 0);
            chk("run_hold_reset", a_cpu_reset, 0);
            chk("run_no_res", a_res_valid, 0);
            chk("run_no_done", a_host_done, 0);
        end
        @(negedge clk);
        a_cpu_done = 1'b0;
        if (to) begin
            chk("to_timeout", a_timeout, 1);
            chk("to_host_done", a_host_done, 1);
            chk("to_no_res", a_res_valid, 0);
            chk("to_cpu_reset", a_cpu_reset, 1);
        end else begin
            chk("drain_res_valid", a_res_valid, 1);
            chk("drain_no_timeout", a_timeout, 0);
            chk("drain_cpu_reset", a_cpu_reset, 1);
            chk("drain_mem_sel", a_mem_sel, 1);
        end
    endtask

    // stall < 0: random 0..3 wait cycles per beat; abort_at >= 0: reset before that beat
    task automatic do_drain(input int stall, input int abort_at);
        for (int unsigned i = 0; i < rlen(); i++) begin
            int unsigned s;
            logic [7:0]  want;
            s    = (stall < 0) ? $urandom_range(0, 3) : stall;
            want = refm[act][8'((rbase() + i) % 256)];
            if (abort_at >= 0 && i == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_res_valid", a_res_valid, 0);
                chk("abort_cpu_reset", a_cpu_reset, 1);
                chk("abort_busy", a_busy, 0);
                chk("abort_mem_sel", a_mem_sel, 1);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            for (int unsigned j = 0; j <= s; j++) begin
                res_ready = (j == s);
                #1;
                chk("res_valid", a_res_valid, 1);
                chk("res_data", a_res_data, want);
                chk("res_addr", a_mem_addr, (rbase() + i) % 256);
                chk("res_no_write", a_mem_wr_en, 0);
                @(negedge clk);
            end
            res_ready = 1'b0;
        end
        chk("fin_host_done", a_host_done, 1);
        chk("fin_res_valid", a_res_valid, 0);
        chk("fin_busy", a_busy, 1);
    endtask

    task automatic do_fin(input bit start_in_fin, input bit exp_to);
        if (start_in_fin) a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("idle_host_done", a_host_done, 0);
        chk("idle_busy", a_busy, 0);
        chk("idle_cpu_reset", a_cpu_reset, 1);
        chk("idle_mem_sel", a_mem_sel, 1);
        chk("idle_timeout", a_timeout, exp_to);
        @(negedge clk);
        chk("fin_start_ignored", a_ld_ready, 0);
    endtask

    initial begin
        reset = 1'b1; act = 1'b0; a_start = 1'b0; a_cpu_done = 1'b0;
        ld_valid = 1'b0; ld_data = '0; res_ready = 1'b0;
        pl_en = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_cpu_reset", a_cpu_reset, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_ld_ready", a_ld_ready, 0);
        chk("rst_wr_en", a_mem_wr_en, 0);
        chk("rst_host_done", a_host_done, 0);
        chk("rst_timeout", a_timeout, 0);
        chk("rst_mem_sel", a_mem_sel, 1);
        chk("rst_cpu_req", a_cpu_req, 0);

        // Operands 0x00..0x1F back to back, results 0xA0+i, 3 stall cycles per beat
        preload(1'b1);
        do_start(); do_load(0); do_run(100); do_drain(3, -1); do_fin(1'b1, 1'b0);

        // Every-other-cycle load, random data, done delay and stalls
        preload(1'b0);
        do_start(); do_load(1); do_run(int'($urandom_range(1, 200))); do_drain(-1, -1); do_fin(1'b0, 1'b0);

        // Small instance: wrapped addresses, done already high when RUN begins
        act = 1'b1;
        preload(1'b0);
        do_start(); do_load(2); do_run(0); do_drain(-1, -1); do_fin(1'b0, 1'b0);

        // Watchdog expiry, then done coinciding with the watchdog limit
        do_start(); do_load(2); do_run(-1); do_fin(1'b1, 1'b1);
        preload(1'b0);
        do_start(); do_load(0); do_run(int'(T_TMO) - 1); do_drain(0, -1); do_fin(1'b0, 1'b0);

        // Reset in the middle of a drain, then a clean run
        act = 1'b0;
        preload(1'b0);
        do_start(); do_load(2); do_run(3); do_drain(1, 5);
        chk("post_abort_busy", a_busy, 0);
        chk("post_abort_ld_ready", a_ld_ready, 0);
        preload(1'b0);
        do_start(); do_load(0); do_run(int'($urandom_range(1, 50))); do_drain(-1, -1); do_fin(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
